pipe_mdu_seq: RTL and testbench
===============================

// Module: pipe_mdu_seq
// PURPOSE
//  Iterative multiply/divide sequencer with architectural HI/LO registers for the 5-stage pipeline.
//  Accepts MULT/MULTU/DIV/DIVU from EX and runs a shift-add or restoring-divide loop, one bit per cycle.
//  Asserts stall to the ID stage while a result is pending and ID holds MFHI/MFLO or another HI/LO instruction.
//  Single clock domain; reset asynchronous, active-low.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are WIDTH bits each; iteration count = WIDTH
// PORTS
//  clk      in   1      system clock, rising edge
//  clrn     in   1      asynchronous active-low reset
//  start    in   1      EX holds a mult/div op this cycle
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a        in   WIDTH  rs operand (multiplicand/dividend)
//  b        in   WIDTH  rt operand (multiplier/divisor)
//  id_mfhi  in   1      ID holds MFHI
//  id_mflo  in   1      ID holds MFLO
//  id_mdop  in   1      ID holds MULT*/DIV*/MTHI/MTLO
//  wr_hi    in   1      MTHI write (from WB)
//  wr_lo    in   1      MTLO write (from WB)
//  wdata    in   WIDTH  MTHI/MTLO data
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
//  busy     out  1      operation in flight (RUN or FIX)
//  stall    out  1      busy & (id_mfhi | id_mflo | id_mdop), combinational
//  done     out  1      one-cycle pulse when HI/LO are updated
// BEHAVIOUR
//  Reset (clrn=0, any time, including mid-operation): state=IDLE, hi=lo=0, busy=0, done=0, cnt=0. The operation in flight is discarded.
//  FSM states: IDLE -> RUN -> FIX -> IDLE.
//   IDLE: if start, capture |a| and |b| (abs only for signed ops), the sign flags sa/sb, and op; set cnt=WIDTH-1; go to RUN.
//   RUN: one partial-product or restoring-subtract step per cycle.
//        At cnt==0, go to FIX; otherwise decrement cnt. RUN lasts exactly WIDTH cycles.
//   FIX: apply signs and write HI/LO; go to IDLE; done=1 in the following cycle.
//  Latency: start sampled in cycle T; new HI/LO visible from cycle T+WIDTH+2 (34 for WIDTH=32).
//   busy=1 during cycles T+1 through T+WIDTH+1.
//  Signed results:
//   MULT: {hi,lo} = negate the 2*WIDTH-bit product if sa^sb.
//   DIV: lo = quotient, negated if sa^sb; hi = remainder, negated if sa.
//   Unsigned ops use the operands unchanged; no sign fix.
//  Divide by zero (b==0, DIV or DIVU): after full latency, lo = all ones and hi = original a. No trap.
//  DIV 0x80000000 / -1: lo = 0x80000000, hi = 0; falls out of the abs/negate rule with no special case.
//  A start while busy is ignored; stall prevents it in legal code. The bench asserts it never occurs.
//  MTHI/MTLO writes: honoured only in IDLE with start=0; otherwise dropped.
//   wr_hi and wr_lo in the same cycle write both registers.
//  Forwarding: none needed. stall holds MFHI/MFLO until state=IDLE, by which time HI/LO are already written.
//  HI/LO hold their value in all cycles except the FIX->IDLE edge and MT writes.
// TESTING
//  MULT a=7, b=6 -> busy for 33 cycles; hi=0, lo=42; done pulses exactly once at T+34.
//  MULT a=-3, b=5 -> hi=FFFFFFFF, lo=FFFFFFF1. MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
//  DIV a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=100, b=0 -> lo=FFFFFFFF, hi=100.
//  Start MULT, then raise id_mflo at T+1 -> stall=1 through T+33; stall=0 at T+34 and lo shows the new value.
//  Pulse clrn low at T+10 of a DIV -> busy=0, hi=lo=0 immediately; a fresh MULTU 2*3 then gives lo=6.
//  wr_lo=1, wdata=55 while idle -> lo=55 next cycle; the same write issued during RUN is dropped.

Source files
------------

// File: rtl/pipe_mdu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_mdu_seq_if
//  Description : EX/ID/WB-facing signal bundle for the multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_mdu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             id_mfhi;
    logic             id_mflo;
    logic             id_mdop;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;

    modport master (
        output start, op, a, b, id_mfhi, id_mflo, id_mdop, wr_hi, wr_lo, wdata,
        input  hi, lo, busy, stall, done
    );

    modport slave (
        input  start, op, a, b, id_mfhi, id_mflo, id_mdop, wr_hi, wr_lo, wdata,
        output hi, lo, busy, stall, done
    );
endinterface
`default_nettype wire

// File: rtl/pipe_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_mdu_seq
//  Description : Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          clrn,
    pipe_mdu_seq_if.slave bus
);
    localparam int               CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q,   opnd_d;
    logic             is_div_q, is_div_d;
    logic             sa_q,     sa_d;
    logic             sb_q,     sb_d;
    logic             bz_q,     bz_d;
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] lo_q,     lo_d;
    logic             done_q,   done_d;

    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_signed = ~bus.op[0];
    assign w_sa     = w_signed & bus.a[WIDTH-1];
    assign w_sb     = w_signed & bus.b[WIDTH-1];
    assign w_abs_a  = w_sa ? (~bus.a + 1'b1) : bus.a;
    assign w_abs_b  = w_sb ? (~bus.b + 1'b1) : bus.b;

    // Multiply: {acc_hi,acc_lo} shifts right; acc_lo starts as the multiplier.
    assign w_mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    assign w_div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, opnd_q};

    assign w_prod     = {acc_hi_q, acc_lo_q};
    assign w_prod_fix = (sa_q ^ sb_q) ? (~w_prod + 1'b1) : w_prod;
    // A zero divisor always yields an all-ones quotient regardless of sign.
    assign w_quo_fix  = bz_q ? {WIDTH{1'b1}}
                      : ((sa_q ^ sb_q) ? (~acc_lo_q + 1'b1) : acc_lo_q);
    assign w_rem_fix  = sa_q ? (~acc_hi_q + 1'b1) : acc_hi_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bz_d     = bz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    is_div_d = bus.op[1];
                    sa_d     = w_sa;
                    sb_d     = w_sb;
                    bz_d     = bus.op[1] & (bus.b == {WIDTH{1'b0}});
                    acc_hi_d = {WIDTH{1'b0}};
                    acc_lo_d = bus.op[1] ? w_abs_a : w_abs_b;
                    opnd_d   = bus.op[1] ? w_abs_b : w_abs_a;
                    cnt_d    = CNT_MAX;
                    state_d  = S_RUN;
                end else begin
                    if (bus.wr_hi) hi_d = bus.wdata;
                    if (bus.wr_lo) lo_d = bus.wdata;
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    acc_hi_d = w_div_diff[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], ~w_div_diff[WIDTH]};
                end else begin
                    acc_hi_d = w_mul_sum[WIDTH:1];
                    acc_lo_d = {w_mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = w_rem_fix;
                    lo_d = w_quo_fix;
                end else begin
                    hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = w_prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            acc_hi_q <= {WIDTH{1'b0}};
            acc_lo_q <= {WIDTH{1'b0}};
            opnd_q   <= {WIDTH{1'b0}};
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bz_q     <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bz_q     <= bz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.stall = bus.busy & (bus.id_mfhi | bus.id_mflo | bus.id_mdop);
    assign bus.done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_mdu_seq
//  Description : Self-checking bench for pipe_mdu_seq against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_mdu_seq;
    logic clk;
    logic clrn;
    int   tests;
    int   fails;

    pipe_mdu_seq_if #(.WIDTH(32)) bus ();

    pipe_mdu_seq #(.WIDTH(32)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clrn) begin
            assert (!(bus.start && bus.busy)) else begin
                fails++;
                $error("FAIL start_while_busy observed start=1 busy=1 required never");
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {hi,lo} from plain signed/unsigned 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa64, sb64, q, r;
        logic [63:0] p;
        sa64 = longint'($signed(a));
        sb64 = longint'($signed(b));
        case (op)
            2'b00: begin p = 64'(sa64 * sb64); return p; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; return p; end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa64 / sb64;
                r = sa64 % sb64;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // mode 0: plain op; 1: MTHI/MTLO during RUN; 2: MTLO alongside start.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int mode);
        logic [63:0] exp;
        logic [63:0] saved;
        logic [2:0]  ids;
        int          n;
        exp   = model(op, a, b);
        saved = {bus.hi, bus.lo};
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (mode == 2) begin
            bus.wr_lo = 1'b1;
            bus.wdata = 32'h5A5A_0F0F;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_lo = 1'b0;
        if (mode == 2) check({tag, "_mt_with_start"}, {bus.hi, bus.lo}, saved);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            if (mode == 1 && n == 0) begin
                bus.wr_hi = 1'b1;
                bus.wr_lo = 1'b1;
                bus.wdata = 32'hDEAD_BEEF;
            end
            if (mode == 1 && n == 1) begin
                bus.wr_hi = 1'b0;
                bus.wr_lo = 1'b0;
                check({tag, "_mt_in_run"}, {bus.hi, bus.lo}, saved);
            end
            ids = 3'($urandom);
            {bus.id_mfhi, bus.id_mflo, bus.id_mdop} = ids;
            #1;
            check({tag, "_stall"}, {63'b0, bus.stall}, {63'b0, |ids});
            n++;
            @(negedge clk);
        end
        bus.id_mfhi = 1'b0;
        bus.id_mdop = 1'b0;
        bus.id_mflo = 1'b1;
        #1;
        check({tag, "_busy_cycles"}, 64'(n), 64'd33);
        check({tag, "_done"}, {63'b0, bus.done}, 64'd1);
        check({tag, "_stall_idle"}, {63'b0, bus.stall}, 64'd0);
        check({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
        bus.id_mflo = 1'b0;
        @(negedge clk);
        check({tag, "_done_low"}, {63'b0, bus.done}, 64'd0);
        check({tag, "_hilo_hold"}, {bus.hi, bus.lo}, exp);
    endtask

    initial begin
        logic [63:0] saved;
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        int          sel;
        tests = 0;
        fails = 0;
        clrn  = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.id_mfhi = 1'b0; bus.id_mflo = 1'b0; bus.id_mdop = 1'b0;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_busy", {63'b0, bus.busy}, 64'd0);
        check("rst_done", {63'b0, bus.done}, 64'd0);
        clrn = 1'b1;
        @(negedge clk);

        run_op("mult_7x6",      2'b00, 32'd7,          32'd6,          0);
        check("mult_7x6_lo42", {32'b0, bus.lo}, 64'd42);
        run_op("mult_m3x5",     2'b00, 32'hFFFF_FFFD,  32'd5,          0);
        run_op("multu_max",     2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0);
        check("multu_max_spec", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("div_m7_2",      2'b10, 32'hFFFF_FFF9,  32'd2,          0);
        check("div_m7_2_spec", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_by0",      2'b11, 32'd100,        32'd0,          0);
        run_op("div_min_m1",    2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  1);
        run_op("div_neg_by0",   2'b10, 32'hFFFF_FFFB,  32'd0,          2);

        // MTLO alone, then MTHI+MTLO together, while idle.
        saved = {bus.hi, bus.lo};
        bus.wr_lo = 1'b1; bus.wdata = 32'd55;
        @(negedge clk);
        bus.wr_lo = 1'b0;
        check("mtlo_idle", {bus.hi, bus.lo}, {saved[63:32], 32'd55});
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'h1234_5678;
        @(negedge clk);
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        check("mt_both_idle", {bus.hi, bus.lo}, 64'h1234_5678_1234_5678);

        // Asynchronous reset in the middle of a DIV.
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd1000; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        clrn = 1'b0;
        #1;
        check("midrst_busy", {63'b0, bus.busy}, 64'd0);
        check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        run_op("multu_2x3", 2'b01, 32'd2, 32'd3, 0);

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      rb = 32'd0;
            else if (sel == 1) rb = 32'hFFFF_FFFF;
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            else               rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            run_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
